// File: rtl/uart_pkg.sv
// Shared types and constants for the serial transmit subsystem.
package uart_pkg;

   localparam int unsigned BYTE_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      ARB,
      LOAD,
      ACK,
      DONE,
      REL
   } arb_state_e;

endpackage

// File: rtl/uart_tx_arb_if.sv
// Requester-side and uart_tx-side signals of the transmit arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface uart_tx_arb_if
   import uart_pkg::*;
#(
   parameter int unsigned N_REQ = 4
) ();

   logic [N_REQ-1:0]        req_valid_i;
   logic [N_REQ*BYTE_W-1:0] req_data_i;
   logic [N_REQ-1:0]        req_last_i;
   logic [N_REQ-1:0]        req_ready_o;
   logic                    tx_start_o;
   logic [BYTE_W-1:0]       tx_data_o;
   logic                    tx_busy_i;
   logic [N_REQ-1:0]        grant_o;
   logic                    err_ack_o;

   modport master (
      output req_valid_i, req_data_i, req_last_i, tx_busy_i,
      input  req_ready_o, tx_start_o, tx_data_o, grant_o, err_ack_o
   );

   modport slave (
      input  req_valid_i, req_data_i, req_last_i, tx_busy_i,
      output req_ready_o, tx_start_o, tx_data_o, grant_o, err_ack_o
   );

endinterface

// File: rtl/uart_tx_arb_rr_arbiter.sv
// Combinational round-robin picker: first active request at or after ptr_i.
module rr_arbiter #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0]         req_i,
   input  logic [$clog2(N)-1:0] ptr_i,
   output logic [N-1:0]         gnt_o,
   output logic                 any_o
);

   localparam int unsigned PtrW = $clog2(N);

   logic [PtrW-1:0] idx;

   // Walk ptr_i, ptr_i+1, ... (mod N) and grant the first active request
   always_comb begin
      gnt_o = '0;
      any_o = 1'b0;
      idx   = '0;
      for (int unsigned i = 0; i < N; i++) begin
         idx = PtrW'((32'(ptr_i) + i) % N);
         if (!any_o && req_i[idx]) begin
            gnt_o[idx] = 1'b1;
            any_o      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arb.sv
// Packet-granular round-robin arbiter sharing one uart_tx among N_REQ requesters.
// Bytes are handed to uart_tx one at a time through the start/busy handshake.
module uart_tx_arb
   import uart_pkg::*;
#(
   parameter int unsigned N_REQ     = 4,
   parameter int unsigned BURST_MAX = 16,
   parameter int unsigned STALL_MAX = 255,
   parameter int unsigned ACK_MAX   = 64,
   parameter int unsigned GAP_CYC   = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   uart_tx_arb_if.slave  bus
);

   localparam int unsigned PtrW   = $clog2(N_REQ);
   localparam int unsigned CntW   = $clog2(BURST_MAX + 1);
   localparam int unsigned StallW = $clog2(STALL_MAX + 1);
   localparam int unsigned AckW   = $clog2(ACK_MAX + 1);
   localparam int unsigned GapW   = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

   arb_state_e        state_q;
   logic [N_REQ-1:0]  grant_q;
   logic [PtrW-1:0]   ptr_q;
   logic [CntW-1:0]   cnt_q;
   logic [StallW-1:0] stall_q;
   logic [AckW-1:0]   ack_q;
   logic [GapW-1:0]   gap_q;
   logic [BYTE_W-1:0] tx_data_q;
   logic              last_q;
   logic              tx_start_q;
   logic              err_q;

   logic [N_REQ-1:0]  arb_gnt;
   logic              arb_any;
   logic [PtrW-1:0]   win_idx;
   logic [PtrW-1:0]   ptr_next;
   logic [BYTE_W-1:0] sel_data;
   logic              sel_last;
   logic              sel_valid;
   logic              accept;

   rr_arbiter #(
      .N (N_REQ)
   ) u_rr (
      .req_i (bus.req_valid_i),
      .ptr_i (ptr_q),
      .gnt_o (arb_gnt),
      .any_o (arb_any)
   );

   // Mux the granted requester's lane and encode the arbitration winner
   always_comb begin
      sel_data  = '0;
      sel_last  = 1'b0;
      sel_valid = 1'b0;
      win_idx   = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (grant_q[i]) begin
            sel_data  = bus.req_data_i[i*BYTE_W +: BYTE_W];
            sel_last  = bus.req_last_i[i];
            sel_valid = bus.req_valid_i[i];
         end
         if (arb_gnt[i]) begin
            win_idx = PtrW'(i);
         end
      end
   end

   assign ptr_next = (32'(win_idx) == N_REQ - 1) ? '0 : win_idx + PtrW'(1);

   // Never accept while uart_tx is still busy, so a start can't land on a live frame
   assign accept = (state_q == LOAD) && sel_valid && !bus.tx_busy_i;

   // Packet sequencer: arbitration, per-byte handshake, stall/burst/ack limits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         ptr_q      <= '0;
         cnt_q      <= '0;
         stall_q    <= '0;
         ack_q      <= '0;
         gap_q      <= '0;
         tx_data_q  <= '0;
         last_q     <= 1'b0;
         tx_start_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         tx_start_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (|bus.req_valid_i) begin
                  state_q <= ARB;
               end
            end
            ARB: begin
               if (arb_any) begin
                  grant_q <= arb_gnt;
                  ptr_q   <= ptr_next;
                  cnt_q   <= '0;
                  stall_q <= '0;
                  state_q <= LOAD;
               end else begin
                  state_q <= IDLE;
               end
            end
            LOAD: begin
               if (accept) begin
                  tx_data_q  <= sel_data;
                  last_q     <= sel_last;
                  tx_start_q <= 1'b1;
                  ack_q      <= '0;
                  if (32'(cnt_q) < BURST_MAX) begin
                     cnt_q <= cnt_q + CntW'(1);
                  end
                  state_q <= ACK;
               end else if (!sel_valid) begin
                  if (32'(stall_q) + 32'd1 >= STALL_MAX) begin
                     grant_q <= '0;
                     gap_q   <= '0;
                     state_q <= REL;
                  end else begin
                     stall_q <= stall_q + StallW'(1);
                  end
               end
            end
            ACK: begin
               if (bus.tx_busy_i) begin
                  state_q <= DONE;
               end else if (32'(ack_q) + 32'd1 >= ACK_MAX) begin
                  // uart_tx never acknowledged: flag it and carry on as if sent
                  err_q   <= 1'b1;
                  state_q <= DONE;
               end else begin
                  ack_q <= ack_q + AckW'(1);
               end
            end
            DONE: begin
               if (!bus.tx_busy_i) begin
                  if (last_q || (32'(cnt_q) >= BURST_MAX)) begin
                     grant_q <= '0;
                     gap_q   <= '0;
                     state_q <= REL;
                  end else begin
                     stall_q <= '0;
                     state_q <= LOAD;
                  end
               end
            end
            REL: begin
               if (32'(gap_q) + 32'd1 >= GAP_CYC) begin
                  state_q <= IDLE;
               end else begin
                  gap_q <= gap_q + GapW'(1);
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready_o = accept ? grant_q : '0;
   assign bus.tx_start_o  = tx_start_q;
   assign bus.tx_data_o   = tx_data_q;
   assign bus.grant_o     = grant_q;
   assign bus.err_ack_o   = err_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: requester FIFOs and a uart_tx model
// (busy rises 1 clk after start and holds for 10 clk).
module tb_uart_tx_arb;
   import uart_pkg::*;

   localparam int NR = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_tx_arb_if #(.N_REQ(NR)) bus ();

   uart_tx_arb #(
      .N_REQ     (NR),
      .BURST_MAX (16),
      .STALL_MAX (255),
      .ACK_MAX   (64),
      .GAP_CYC   (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Requester FIFOs: {last, data}
   logic [8:0]  rmem [NR][64];
   logic [5:0]  rhead [NR];
   logic [5:0]  rtail [NR];

   bit          model_ack = 1'b1;
   int          busy_cnt = 0;
   logic [NR-1:0] acc;
   bit          start_seen;
   logic [7:0]  cur_data;
   int          cyc = 0;
   int          viol_cnt = 0;

   logic [7:0]    log_data [$];
   logic [NR-1:0] log_gnt [$];
   int            log_cyc [$];

   int n_vec = 0;
   int n_err = 0;

   // Requester driver, uart_tx model and protocol monitor
   initial begin
      for (int k = 0; k < NR; k++) begin
         rhead[k] = '0;
         rtail[k] = '0;
      end
      bus.req_valid_i = '0;
      bus.req_data_i  = '0;
      bus.req_last_i  = '0;
      bus.tx_busy_i   = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         acc        = bus.req_ready_o;
         start_seen = bus.tx_start_o;
         if (bus.tx_start_o) begin
            log_data.push_back(bus.tx_data_o);
            log_gnt.push_back(bus.grant_o);
            log_cyc.push_back(cyc);
            cur_data = bus.tx_data_o;
            if (bus.tx_busy_i || (bus.req_ready_o != '0)) viol_cnt++;
         end
         if (rst_n && bus.tx_busy_i && (bus.tx_data_o != cur_data)) viol_cnt++;
         @(posedge clk);
         #1;
         if (busy_cnt > 0) busy_cnt--;
         if (!rst_n) busy_cnt = 0;
         else if (start_seen && model_ack) busy_cnt = 10;
         bus.tx_busy_i = (busy_cnt != 0);
         for (int k = 0; k < NR; k++) begin
            if (acc[k] && (rhead[k] != rtail[k])) rhead[k] = rhead[k] + 6'd1;
            if (rhead[k] != rtail[k]) begin
               bus.req_valid_i[k]        = 1'b1;
               bus.req_data_i[k*8 +: 8]  = rmem[k][rhead[k]][7:0];
               bus.req_last_i[k]         = rmem[k][rhead[k]][8];
            end else begin
               bus.req_valid_i[k]        = 1'b0;
               bus.req_data_i[k*8 +: 8]  = 8'($urandom);
               bus.req_last_i[k]         = 1'b0;
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want $finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic push(input int k, input logic [7:0] d, input logic l);
      rmem[k][rtail[k]] = {l, d};
      rtail[k] = rtail[k] + 6'd1;
   endtask

   task automatic clear_log();
      log_data.delete();
      log_gnt.delete();
      log_cyc.delete();
   endtask

   function automatic bit all_empty();
      for (int k = 0; k < NR; k++) if (rhead[k] != rtail[k]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic wait_quiet(input int budget, output bit ok);
      int q;
      q  = 0;
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         tick();
         if (all_empty() && busy_cnt == 0 && bus.grant_o == '0) q++;
         else q = 0;
         if (q >= 6) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      n_vec++;
      if (bus.grant_o !== 4'b0000) begin
         n_err++; $display("FAIL reset_grant: got %b want 0000", bus.grant_o);
      end
      n_vec++;
      if (bus.tx_start_o !== 1'b0) begin
         n_err++; $display("FAIL reset_start: got %b want 0", bus.tx_start_o);
      end
      n_vec++;
      if (bus.tx_data_o !== 8'h00) begin
         n_err++; $display("FAIL reset_data: got %h want 00", bus.tx_data_o);
      end
      n_vec++;
      if (bus.req_ready_o !== 4'b0000) begin
         n_err++; $display("FAIL reset_ready: got %b want 0000", bus.req_ready_o);
      end
      n_vec++;
      if (bus.err_ack_o !== 1'b0) begin
         n_err++; $display("FAIL reset_err: got %b want 0", bus.err_ack_o);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      logic [3:0]    st;
      logic [NR-1:0] gn [4];
      logic [NR-1:0] rd [4];
      bit ok;
      clear_log();
      tick();
      push(0, 8'hA5, 1'b0);
      push(0, 8'h3C, 1'b1);
      @(posedge clk);
      #2;
      for (int i = 0; i < 4; i++) begin
         tick();
         st[i] = bus.tx_start_o;
         gn[i] = bus.grant_o;
         rd[i] = bus.req_ready_o;
      end
      n_vec++;
      if (st !== 4'b1000) begin
         n_err++; $display("FAIL single_latency: start pattern %b want 1000", st);
      end
      n_vec++;
      if (gn[1] !== 4'b0000) begin
         n_err++; $display("FAIL single_grant_arb: got %b want 0000", gn[1]);
      end
      n_vec++;
      if (gn[2] !== 4'b0001) begin
         n_err++; $display("FAIL single_grant: got %b want 0001", gn[2]);
      end
      n_vec++;
      if (rd[2] !== 4'b0001) begin
         n_err++; $display("FAIL single_ready: got %b want 0001", rd[2]);
      end
      wait_quiet(300, ok);
      n_vec++;
      if (!ok) begin
         n_err++; $display("FAIL single_release: got busy/granted want idle");
      end
      n_vec++;
      if (log_data.size() != 2) begin
         n_err++; $display("FAIL single_count: got %0d want 2", log_data.size());
      end else begin
         n_vec++;
         if (log_data[0] !== 8'hA5 || log_data[1] !== 8'h3C) begin
            n_err++; $display("FAIL single_data: got %h %h want a5 3c", log_data[0], log_data[1]);
         end
         n_vec++;
         if (log_gnt[0] !== 4'b0001 || log_gnt[1] !== 4'b0001) begin
            n_err++; $display("FAIL single_gnt: got %b %b want 0001", log_gnt[0], log_gnt[1]);
         end
         n_vec++;
         if (log_cyc[1] - log_cyc[0] != 13) begin
            n_err++; $display("FAIL single_spacing: got %0d want 13", log_cyc[1] - log_cyc[0]);
         end
      end
   endtask

   task automatic test_round_robin();
      logic [7:0]    ed [6] = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h12, 8'h13};
      logic [NR-1:0] eg [6] = '{4'b0001, 4'b0001, 4'b0100, 4'b0100, 4'b0001, 4'b0001};
      int            es [5] = '{13, 17, 13, 17, 13};
      bit ok;
      rst_n = 1'b0;
      tick();
      clear_log();
      push(0, 8'h10, 1'b0); push(0, 8'h11, 1'b1);
      push(0, 8'h12, 1'b0); push(0, 8'h13, 1'b1);
      push(2, 8'h20, 1'b0); push(2, 8'h21, 1'b1);
      repeat (2) tick();
      rst_n = 1'b1;
      wait_quiet(600, ok);
      n_vec++;
      if (!ok || log_data.size() != 6) begin
         n_err++; $display("FAIL rr_count: got %0d starts (idle=%0d) want 6", log_data.size(), ok);
      end
      for (int i = 0; i < 6 && i < log_data.size(); i++) begin
         n_vec++;
         if (log_data[i] !== ed[i] || log_gnt[i] !== eg[i]) begin
            n_err++;
            $display("FAIL rr_byte%0d: got %h/%b want %h/%b", i, log_data[i], log_gnt[i], ed[i], eg[i]);
         end
         if (i > 0) begin
            n_vec++;
            if (log_cyc[i] - log_cyc[i-1] != es[i-1]) begin
               n_err++;
               $display("FAIL rr_gap%0d: got %0d want %0d", i, log_cyc[i] - log_cyc[i-1], es[i-1]);
            end
         end
      end
   endtask

   task automatic test_burst_limit();
      logic [7:0]    wd;
      logic [NR-1:0] wg;
      bit ok;
      clear_log();
      for (int i = 0; i < 20; i++) push(1, 8'h40 + 8'(i), 1'b0);
      push(3, 8'h77, 1'b1);
      wait_quiet(3000, ok);
      n_vec++;
      if (!ok || log_data.size() != 21) begin
         n_err++; $display("FAIL burst_count: got %0d starts (idle=%0d) want 21", log_data.size(), ok);
      end
      for (int i = 0; i < 21 && i < log_data.size(); i++) begin
         if (i < 16) begin
            wd = 8'h40 + 8'(i);     wg = 4'b0010;
         end else if (i == 16) begin
            wd = 8'h77;             wg = 4'b1000;
         end else begin
            wd = 8'h40 + 8'(i - 1); wg = 4'b0010;
         end
         n_vec++;
         if (log_data[i] !== wd || log_gnt[i] !== wg) begin
            n_err++;
            $display("FAIL burst_byte%0d: got %h/%b want %h/%b", i, log_data[i], log_gnt[i], wd, wg);
         end
      end
   endtask

   task automatic test_stall();
      int held;
      bit ok;
      clear_log();
      push(0, 8'h51, 1'b0);
      for (int i = 0; i < 50 && log_data.size() == 0; i++) tick();
      held = 0;
      for (int i = 0; i < 400; i++) begin
         if (bus.grant_o == 4'b0001) held++;
         else break;
         tick();
      end
      n_vec++;
      if (held != 267) begin
         n_err++; $display("FAIL stall_hold: grant held %0d cycles want 267", held);
      end
      repeat (40) tick();
      n_vec++;
      if (log_data.size() != 1) begin
         n_err++; $display("FAIL stall_no_extra: got %0d starts want 1", log_data.size());
      end
      push(0, 8'h52, 1'b1);
      wait_quiet(300, ok);
      n_vec++;
      if (!ok || log_data.size() != 2 || log_data[log_data.size()-1] !== 8'h52) begin
         n_err++; $display("FAIL stall_next: got %0d starts want 2 ending in 52", log_data.size());
      end
   endtask

   task automatic test_ack_timeout();
      bit ok;
      clear_log();
      model_ack = 1'b0;
      push(2, 8'h66, 1'b1);
      for (int i = 0; i < 50 && log_data.size() == 0; i++) tick();
      n_vec++;
      if (log_data.size() != 1) begin
         n_err++; $display("FAIL ack_start: got %0d starts want 1", log_data.size());
      end
      repeat (63) tick();
      n_vec++;
      if (bus.err_ack_o !== 1'b0) begin
         n_err++; $display("FAIL ack_early: err %b at 63 cycles want 0", bus.err_ack_o);
      end
      tick();
      n_vec++;
      if (bus.err_ack_o !== 1'b1) begin
         n_err++; $display("FAIL ack_flag: err %b at 64 cycles want 1", bus.err_ack_o);
      end
      wait_quiet(300, ok);
      model_ack = 1'b1;
      push(3, 8'h99, 1'b1);
      wait_quiet(300, ok);
      n_vec++;
      if (!ok || log_data.size() != 2 || log_data[log_data.size()-1] !== 8'h99) begin
         n_err++; $display("FAIL ack_next: got %0d starts want 2 ending in 99", log_data.size());
      end
      n_vec++;
      if (bus.err_ack_o !== 1'b1) begin
         n_err++; $display("FAIL ack_sticky: err %b want 1", bus.err_ack_o);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      clear_log();
      push(1, 8'hC1, 1'b0);
      push(1, 8'hC2, 1'b1);
      for (int i = 0; i < 50 && log_data.size() == 0; i++) tick();
      repeat (5) tick();
      n_vec++;
      if (bus.grant_o !== 4'b0010 || bus.tx_data_o !== 8'hC1) begin
         n_err++; $display("FAIL rmid_pre: got %b/%h want 0010/c1", bus.grant_o, bus.tx_data_o);
      end
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (bus.grant_o !== 4'b0000 || bus.tx_start_o !== 1'b0 || bus.req_ready_o !== 4'b0000) begin
         n_err++;
         $display("FAIL rmid_ctl: got %b/%b/%b want 0000/0/0000",
                  bus.grant_o, bus.tx_start_o, bus.req_ready_o);
      end
      n_vec++;
      if (bus.tx_data_o !== 8'h00 || bus.err_ack_o !== 1'b0) begin
         n_err++; $display("FAIL rmid_data: got %h/%b want 00/0", bus.tx_data_o, bus.err_ack_o);
      end
      clear_log();
      push(0, 8'hE1, 1'b1);
      push(2, 8'hF1, 1'b1);
      repeat (3) tick();
      rst_n = 1'b1;
      for (int i = 0; i < 50 && log_data.size() == 0; i++) tick();
      n_vec++;
      if (log_data.size() == 0 || log_data[0] !== 8'hE1 || log_gnt[0] !== 4'b0001) begin
         n_err++; $display("FAIL rmid_first: got %0d starts want first e1 from 0001", log_data.size());
      end
      wait_quiet(600, ok);
      n_vec++;
      if (!ok || log_data.size() != 3) begin
         n_err++; $display("FAIL rmid_drain: got %0d starts want 3", log_data.size());
      end
   endtask

   task automatic test_protocol();
      n_vec++;
      if (viol_cnt != 0) begin
         n_err++; $display("FAIL protocol: got %0d violations want 0", viol_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_burst_limit();
      test_stall();
      test_ack_timeout();
      test_reset_mid();
      test_protocol();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
